// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   ALU_DATA_W  default operand/result width (must match the ALU)
//   ALU_*       mode encodings seen on in_mode / alu_mode / out_mode
//   alu_op_t    one buffered operation {mode, a, b}, DATA_W*2+2 bits
package alu_pkg;
   localparam int ALU_DATA_W = 8;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_AND = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_XOR = 2'b11;

   localparam int ALU_OP_W = ALU_DATA_W*2 + 2;

   typedef struct packed {
      logic [1:0]            mode;
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
   } alu_op_t;
endpackage

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: synchronous FIFO, registered storage, async-read head.
//   clk, rst_n    clock, async active-low reset (pointers/count only)
//   push, wdata   write request/data; ignored while full
//   pop           read request; ignored while empty
//   rdata         current head entry (combinational read)
//   count         occupancy 0..DEPTH
//   full, empty   occupancy flags
module alu_op_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // full blocks push even when a pop happens this edge: keeps ready
   // independent of the downstream handshake
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // storage carries no reset; contents are only visible through count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: issue stage in front of the combinational 8-bit ALU.
// Buffers {a,b,mode} ops, presents the FIFO head to the ALU, and registers
// the ALU result on a valid/ready output.
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           op input handshake (in_ready = not full)
//   in_a, in_b, in_mode         op operands and mode
//   alu_a, alu_b, alu_mode      head op to the ALU, zero when empty
//   alu_z                       ALU result (combinational)
//   out_valid/out_ready         result output handshake
//   out_z, out_mode             registered result and the mode that made it
//   count                       FIFO occupancy
module alu_op_issue
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::ALU_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_a,
   input  logic [DATA_W-1:0]      in_b,
   input  logic [1:0]             in_mode,
   output logic [DATA_W-1:0]      alu_a,
   output logic [DATA_W-1:0]      alu_b,
   output logic [1:0]             alu_mode,
   input  logic [DATA_W-1:0]      alu_z,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_z,
   output logic [1:0]             out_mode,
   output logic [$clog2(DEPTH):0] count
);
   localparam int OP_W = DATA_W*2 + 2;

   logic [OP_W-1:0]   head;
   logic [DATA_W-1:0] h_a, h_b;
   logic [1:0]        h_mode;
   logic              full, empty, fire;

   // output slot is free, or being drained this edge
   assign fire     = ~empty & (~out_valid | out_ready);
   assign in_ready = ~full;

   alu_op_fifo #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .wdata ({in_mode, in_a, in_b}),
      .pop   (fire),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign {h_mode, h_a, h_b} = head;

   // stale storage never reaches the ALU
   assign alu_a    = empty ? '0 : h_a;
   assign alu_b    = empty ? '0 : h_b;
   assign alu_mode = empty ? '0 : h_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_z     <= '0;
         out_mode  <= '0;
      end else if (fire) begin
         out_z     <= alu_z;
         out_mode  <= alu_mode;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule
